// File: rtl/tbu_param.sv
// tbu_param: block-based Viterbi traceback for 2^(K-1) states and TB_DEPTH steps per block.
// Latency: the first out_valid is seen TB_DEPTH+1 cycles after the edge that accepts the last vector of a block.
// Backpressure: dec_ready is high only while filling. out_bit and out_last hold while out_valid && !out_ready.
//
// Optional build macro TBU_BEST_STATE_EN: when defined, traceback starts from start_state,
// which is sampled together with the last vector of the block. Otherwise it starts from state 0.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   dec_valid/dec_ready survivor decision vector handshake; dec_in bit s is the decision for state s
//   start_state         traceback start state (only used with TBU_BEST_STATE_EN)
//   out_valid/out_ready decoded bit handshake; out_bit is the bit, out_last marks the last bit of a block
module tbu_param #(
  parameter  int K        = 4,
  parameter  int TB_DEPTH = 16,
  localparam int NSTATE   = 1 << (K - 1),
  localparam int SW       = K - 1,
  localparam int PW       = $clog2(TB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [NSTATE-1:0] dec_in,
  input  logic [SW-1:0]     start_state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);

  localparam logic [PW-1:0] LAST = PW'(TB_DEPTH - 1);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    TRACE = 2'd1,
    EMIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [SW-1:0]   cur_q, cur_d;
  logic            dec_ready_q, dec_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            out_bit_q, out_bit_d;
  logic            out_last_q, out_last_d;

  logic [NSTATE-1:0] mem_q    [TB_DEPTH];
  logic              bitbuf_q [TB_DEPTH];
  logic              mem_we;
  logic              bit_we;

  logic [SW-1:0]   start_sel;
  logic [PW-1:0]   rptr_nxt;
  logic            cur_dec;

`ifdef TBU_BEST_STATE_EN
  assign start_sel = start_state;
`else
  // Zero-terminated trellis: traceback always begins at state 0.
  logic unused_start_state;
  assign unused_start_state = ^start_state;
  assign start_sel = '0;
`endif

  assign rptr_nxt = rptr_q + PW'(1);
  // Survivor decision of the current trace state at the current step.
  assign cur_dec  = mem_q[idx_q][cur_q];

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    idx_d       = idx_q;
    rptr_d      = rptr_q;
    cur_d       = cur_q;
    dec_ready_d = dec_ready_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_last_d  = out_last_q;
    mem_we      = 1'b0;
    bit_we      = 1'b0;

    case (state_q)
      FILL: begin
        if (dec_valid && dec_ready_q) begin
          mem_we = 1'b1;
          if (wptr_q == LAST) begin
            wptr_d      = '0;
            cur_d       = start_sel;
            idx_d       = LAST;
            dec_ready_d = 1'b0;
            state_d     = TRACE;
          end else begin
            wptr_d = wptr_q + PW'(1);
          end
        end
      end

      TRACE: begin
        // The bit decoded at a state is its LSB. The predecessor shifts the
        // state right and takes the stored decision as its new MSB.
        bit_we = 1'b1;
        cur_d  = {cur_dec, cur_q[SW-1:1]};
        if (idx_q == '0) begin
          rptr_d  = '0;
          state_d = EMIT;
        end else begin
          idx_d = idx_q - PW'(1);
        end
      end

      EMIT: begin
        // The first EMIT cycle only loads the output register, because
        // bitbuf[0] is written on the same edge that enters EMIT.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_bit_d   = bitbuf_q[rptr_q];
          out_last_d  = (rptr_q == LAST);
        end else if (out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            dec_ready_d = 1'b1;
            wptr_d      = '0;
            rptr_d      = '0;
            state_d     = FILL;
          end else begin
            rptr_d     = rptr_nxt;
            out_bit_d  = bitbuf_q[rptr_nxt];
            out_last_d = (rptr_nxt == LAST);
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      wptr_q      <= '0;
      idx_q       <= '0;
      rptr_q      <= '0;
      cur_q       <= '0;
      dec_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      idx_q       <= idx_d;
      rptr_q      <= rptr_d;
      cur_q       <= cur_d;
      dec_ready_q <= dec_ready_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_last_q  <= out_last_d;
    end
  end

  // Storage arrays are not reset. Every entry is written before it is read within a block.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wptr_q] <= dec_in;
    end
    if (bit_we) begin
      bitbuf_q[idx_q] <= cur_q[0];
    end
  end

  assign dec_ready = dec_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_tbu_param.sv
// tb_tbu_param: directed and random checks of tbu_param on two instances.
// Instance 0 uses K=4 and TB_DEPTH=8. Instance 1 uses K=5 and TB_DEPTH=12.
// Instance 1 is fed survivor vectors built from a random encoder path, and the decoded bits must equal the encoder input.
module tb_tbu_param;

  localparam int KA = 4;
  localparam int DA = 8;
  localparam int KB = 5;
  localparam int DB = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0]       dec_valid, dec_ready, out_valid, out_ready, out_bit, out_last;
  logic [1:0][15:0] dec_in;
  logic [1:0][3:0]  start_state;

  int checks   = 0;
  int failures = 0;
  logic [15:0] blk [16];
  time t_acc;

  always #5 clk = ~clk;

  tbu_param #(.K(KA), .TB_DEPTH(DA)) u_a (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid[0]), .dec_ready(dec_ready[0]), .dec_in(dec_in[0][7:0]),
    .start_state(start_state[0][2:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_bit(out_bit[0]), .out_last(out_last[0])
  );

  tbu_param #(.K(KB), .TB_DEPTH(DB)) u_b (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid[1]), .dec_ready(dec_ready[1]), .dec_in(dec_in[1][15:0]),
    .start_state(start_state[1][3:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_bit(out_bit[1]), .out_last(out_last[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Send n vectors from blk[]. The last vector carries ss. After a full block,
  // keep dec_valid asserted with junk for a few cycles; it must be ignored.
  task automatic send_block(input int u, input int n, input logic [3:0] ss, input bit junk);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      @(negedge clk);
      while (!dec_ready[u] && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) chk("dec_ready_wait", 32'(dec_ready[u]), 32'd1);
      dec_valid[u]   = 1'b1;
      dec_in[u]      = blk[i];
      start_state[u] = (i == n - 1) ? ss : 4'($urandom);
      @(posedge clk);
      t_acc = $time;
    end
    if (junk) begin
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        dec_in[u]      = 16'($urandom);
        start_state[u] = 4'($urandom);
      end
    end else begin
      @(negedge clk);
    end
    dec_valid[u] = 1'b0;
  endtask

  // Collect n bits. With bp set, out_ready follows the pattern 1,0,0,1 on valid cycles.
  task automatic collect(input int u, input int n, input bit bp,
                         output logic [15:0] got, output int lat);
    int k, cyc, vc;
    logic hv, hb, hl, rdy;
    got = '0; lat = -1; k = 0; cyc = 0; vc = 0; hv = 1'b0; hb = 1'b0; hl = 1'b0;
    while (k < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (out_valid[u]) begin
        if (lat < 0) lat = int'(($time - t_acc - 5) / 10);
        if (hv) chk("hold_stable", {30'd0, out_bit[u], out_last[u]}, {30'd0, hb, hl});
        chk("dec_ready_low_emit", 32'(dec_ready[u]), 32'd0);
        rdy = bp ? ((vc % 4 == 0) || (vc % 4 == 3)) : 1'b1;
        vc++;
        out_ready[u] = rdy;
        if (rdy) begin
          got[k] = out_bit[u];
          chk("out_last", 32'(out_last[u]), 32'(k == n - 1));
          k++;
          hv = 1'b0;
        end else begin
          hv = 1'b1;
          hb = out_bit[u];
          hl = out_last[u];
        end
      end else begin
        if (hv) chk("no_retract", 32'(out_valid[u]), 32'd1);
        hv = 1'b0;
        out_ready[u] = 1'($urandom);
      end
    end
    chk("collect_count", 32'(k), 32'(n));
    @(negedge clk);
    out_ready[u] = 1'b0;
    chk("dec_ready_after_block", 32'(dec_ready[u]), 32'd1);
    chk("out_valid_after_block", 32'(out_valid[u]), 32'd0);
  endtask

  initial begin
    logic [15:0] got, ub;
    logic [3:0]  ss;
    int lat, s, prev, w;
    bit tail0;

    dec_valid = '0; out_ready = '0; dec_in = '0; start_state = '0;
    #12;
    for (int u = 0; u < 2; u++) begin
      chk("rst_dec_ready", 32'(dec_ready[u]), 32'd1);
      chk("rst_out_valid", 32'(out_valid[u]), 32'd0);
      chk("rst_out_bit",   32'(out_bit[u]),   32'd0);
      chk("rst_out_last",  32'(out_last[u]),  32'd0);
    end
    @(negedge clk);
    rst = 1'b1;

    // All-zero block: eight zeros, first valid TB_DEPTH+1 cycles after the last accept.
    for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
    send_block(0, DA, 4'd0, 1'b1);
    collect(0, DA, 1'b0, got, lat);
    chk("zeros_bits", 32'(got[7:0]), 32'h00);
    chk("zeros_latency", 32'(lat), 32'(DA + 1));

    // All-ones block from state 0: trace 0,4,6,7,7,... gives forward 1,1,1,1,1,0,0,0.
    for (int i = 0; i < 16; i++) blk[i] = 16'h00FF;
    send_block(0, DA, 4'd0, 1'b1);
    collect(0, DA, 1'b0, got, lat);
    chk("ones_bits", 32'(got[7:0]), 32'h1F);

    // The same block under backpressure.
    send_block(0, DA, 4'd0, 1'b1);
    collect(0, DA, 1'b1, got, lat);
    chk("ones_bp_bits", 32'(got[7:0]), 32'h1F);
    chk("ones_bp_latency", 32'(lat), 32'(DA + 1));

`ifdef TBU_BEST_STATE_EN
    // Start from state 5: trace 5,2,1,0,... gives forward 0,0,0,0,0,1,0,1.
    for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
    send_block(0, DA, 4'd5, 1'b1);
    collect(0, DA, 1'b0, got, lat);
    chk("best_state_bits", 32'(got[7:0]), 32'hA0);
`endif

    // Reset during FILL: the partial block is dropped and the next block starts at step 0.
    for (int i = 0; i < 16; i++) blk[i] = 16'h00FF;
    send_block(0, 3, 4'd0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_fill_dec_ready", 32'(dec_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    send_block(0, DA, 4'd0, 1'b1);
    collect(0, DA, 1'b0, got, lat);
    chk("after_fill_rst_bits", 32'(got[7:0]), 32'h1F);

    // Reset during TRACE.
    send_block(0, DA, 4'd0, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_trace_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_trace_dec_ready", 32'(dec_ready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;

    // Reset during EMIT, after two bits have been accepted.
    send_block(0, DA, 4'd0, 1'b1);
    w = 0;
    while (!out_valid[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("emit_reached", 32'(out_valid[0]), 32'd1);
    out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_emit_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_emit_dec_ready", 32'(dec_ready[0]), 32'd1);
    out_ready[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // A fresh all-zero block after the resets.
    for (int i = 0; i < 16; i++) blk[i] = 16'h0000;
    send_block(0, DA, 4'd0, 1'b1);
    collect(0, DA, 1'b0, got, lat);
    chk("fresh_zeros_bits", 32'(got[7:0]), 32'h00);

    // Random encoder paths on K=5, TB_DEPTH=12. On the survivor path, the decision at
    // each state points to the real predecessor. All other decisions are random.
    for (int b = 0; b < 8; b++) begin
      tail0 = 1'b1;
`ifdef TBU_BEST_STATE_EN
      tail0 = b[0];
`endif
      s = 0;
      ub = '0;
      for (int t = 0; t < DB; t++) begin
        ub[t] = (tail0 && t >= DB - (KB - 1)) ? 1'b0 : 1'($urandom);
        prev = s;
        s = ((s << 1) | int'(ub[t])) % 16;
        blk[t] = 16'($urandom);
        blk[t][s] = 1'((prev >> 3) & 1);
      end
`ifdef TBU_BEST_STATE_EN
      ss = 4'(s);
`else
      ss = 4'($urandom);
`endif
      send_block(1, DB, ss, 1'b1);
      collect(1, DB, b[1], got, lat);
      chk("random_block_bits", 32'(got[11:0]), 32'(ub[11:0]));
      chk("random_block_latency", 32'(lat), 32'(DB + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
